// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the miniRV hazard controller: write-back selects,
// forwarding selects, controller states and the register-match rule.
package pipe_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [2:0] WB_ALU   = 3'd0;
    localparam logic [2:0] WB_DRAM  = 3'd1;
    localparam logic [2:0] WB_PC4   = 3'd2;
    localparam logic [2:0] WB_IMM   = 3'd3;
    localparam logic [2:0] WB_PCIMM = 3'd4;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } hz_state_e;

    // A writer hits a reader when it writes a non-zero register the reader uses.
    function automatic logic reg_match(input logic [REG_W-1:0] rd, input logic rd_we,
                                       input logic [REG_W-1:0] rs, input logic rs_used);
        return (rd != '0) && (rd == rs) && rd_we && rs_used;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; master is the pipeline side.
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_use_rs1_i;
    logic       id_use_rs2_i;
    logic [4:0] idex_wR_i;
    logic       idex_rf_we_i;
    logic [2:0] idex_wb_sel_i;
    logic [4:0] exm_wR_i;
    logic       exm_rf_we_i;
    logic [2:0] exm_wb_sel_i;
    logic       exm_dram_we_i;
    logic       exm_null_i;
    logic [4:0] wb_wR_i;
    logic       wb_rf_we_i;
    logic       ex_branch_taken_i;
    logic       dram_ready_i;
    logic        pc_stall_o;
    logic        ifid_stall_o;
    logic        idex_stall_o;
    logic        exm_stall_o;
    logic        ifid_flush_o;
    logic        idex_flush_o;
    logic [1:0]  fwd_a_o;
    logic [1:0]  fwd_b_o;
    logic        mem_err_o;
    logic [31:0] stall_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               idex_wR_i, idex_rf_we_i, idex_wb_sel_i,
               exm_wR_i, exm_rf_we_i, exm_wb_sel_i, exm_dram_we_i, exm_null_i,
               wb_wR_i, wb_rf_we_i, ex_branch_taken_i, dram_ready_i,
        input  pc_stall_o, ifid_stall_o, idex_stall_o, exm_stall_o,
               ifid_flush_o, idex_flush_o, fwd_a_o, fwd_b_o, mem_err_o, stall_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               idex_wR_i, idex_rf_we_i, idex_wb_sel_i,
               exm_wR_i, exm_rf_we_i, exm_wb_sel_i, exm_dram_we_i, exm_null_i,
               wb_wR_i, wb_rf_we_i, ex_branch_taken_i, dram_ready_i,
        output pc_stall_o, ifid_stall_o, idex_stall_o, exm_stall_o,
               ifid_flush_o, idex_flush_o, fwd_a_o, fwd_b_o, mem_err_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX operand forwarding select for one source register; EX/DMEM beats DMEM/WB,
// and a load still in EX/DMEM cannot forward (its data is not yet read).
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             rs_used,
    input  logic [REG_W-1:0] exm_wr,
    input  logic             exm_rf_we,
    input  logic [2:0]       exm_wb_sel,
    input  logic             exm_null,
    input  logic [REG_W-1:0] wb_wr,
    input  logic             wb_rf_we,
    output logic [1:0]       sel_c
);

    always_comb begin
        sel_c = FWD_RF;
        if (reg_match(exm_wr, exm_rf_we, rs, rs_used) && (exm_wb_sel != WB_DRAM) && !exm_null) begin
            sel_c = FWD_EXM;
        end else if (reg_match(wb_wr, wb_rf_we, rs, rs_used)) begin
            sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the five-stage miniRV pipeline: memory-wait and
// load-use stalls, branch flushes, EX forwarding selects and a stall counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT      = 255
) (
    input logic         clk_i,
    input logic         rst_n_i,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int unsigned BCNT_W = 2;
    localparam int unsigned TCNT_W = 8;
    localparam int unsigned SCNT_W = 32;
    localparam logic [BCNT_W-1:0] BUBBLE_RELOAD = BCNT_W'(LOAD_USE_BUBBLES - 1);
    localparam logic [TCNT_W-1:0] TIMEOUT_LIM   = TCNT_W'(MEM_TIMEOUT);

    hz_state_e          state_q, state_d, act_st;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic               mem_err_q, mem_err_d;
    logic [SCNT_W-1:0]  stall_cnt_q;
    logic               mem_acc, mem_hold, load_use;
    logic               pc_stall, ifid_stall, idex_stall, exm_stall;
    logic               ifid_flush, idex_flush;
    logic [1:0]         fwd_a, fwd_b;

    fwd_unit u_fwd_a (
        .rs(hz.id_rs1_i), .rs_used(hz.id_use_rs1_i),
        .exm_wr(hz.exm_wR_i), .exm_rf_we(hz.exm_rf_we_i), .exm_wb_sel(hz.exm_wb_sel_i),
        .exm_null(hz.exm_null_i), .wb_wr(hz.wb_wR_i), .wb_rf_we(hz.wb_rf_we_i), .sel_c(fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs(hz.id_rs2_i), .rs_used(hz.id_use_rs2_i),
        .exm_wr(hz.exm_wR_i), .exm_rf_we(hz.exm_rf_we_i), .exm_wb_sel(hz.exm_wb_sel_i),
        .exm_null(hz.exm_null_i), .wb_wr(hz.wb_wR_i), .wb_rf_we(hz.wb_rf_we_i), .sel_c(fwd_b)
    );

    assign mem_acc  = !hz.exm_null_i && (hz.exm_dram_we_i || (hz.exm_wb_sel_i == WB_DRAM));
    assign load_use = (hz.idex_wb_sel_i == WB_DRAM) &&
                      (reg_match(hz.idex_wR_i, hz.idex_rf_we_i, hz.id_rs1_i, hz.id_use_rs1_i) ||
                       reg_match(hz.idex_wR_i, hz.idex_rf_we_i, hz.id_rs2_i, hz.id_use_rs2_i));
    assign mem_hold = !hz.dram_ready_i && ((state_q == ST_MEM_WAIT) || mem_acc);
    // On the ready cycle a pre-empted load-use stall picks up where it left off.
    assign act_st   = (state_q == ST_MEM_WAIT) ? ((bcnt_q != '0) ? ST_LOAD_STALL : ST_RUN)
                                               : state_q;

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        tcnt_d     = '0;
        mem_err_d  = mem_err_q;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        idex_stall = 1'b0;
        exm_stall  = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst_n_i) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_hold) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            exm_stall  = 1'b1;
            if (state_q == ST_MEM_WAIT) begin
                tcnt_d = tcnt_q + TCNT_W'(1);
                if (tcnt_d == TIMEOUT_LIM) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_RUN;
                    bcnt_d    = '0;
                    tcnt_d    = '0;
                end
            end else begin
                state_d = ST_MEM_WAIT;
            end
        end else if (hz.ex_branch_taken_i) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = ST_RUN;
            bcnt_d     = '0;
        end else if (act_st == ST_LOAD_STALL) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            bcnt_d     = bcnt_q - BCNT_W'(1);
            state_d    = (bcnt_d != '0) ? ST_LOAD_STALL : ST_RUN;
        end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            bcnt_d     = BUBBLE_RELOAD;
            state_d    = (BUBBLE_RELOAD != '0) ? ST_LOAD_STALL : ST_RUN;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RUN;
            bcnt_q      <= '0;
            tcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            tcnt_q      <= tcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_q + SCNT_W'(pc_stall);
        end
    end

    assign hz.pc_stall_o   = pc_stall;
    assign hz.ifid_stall_o = ifid_stall;
    assign hz.idex_stall_o = idex_stall;
    assign hz.exm_stall_o  = exm_stall;
    assign hz.ifid_flush_o = ifid_flush;
    assign hz.idex_flush_o = idex_flush;
    assign hz.fwd_a_o      = rst_n_i ? fwd_a : FWD_RF;
    assign hz.fwd_b_o      = rst_n_i ? fwd_b : FWD_RF;
    assign hz.mem_err_o    = mem_err_q;
    assign hz.stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (1 bubble / 255 timeout and
// 3 bubbles / 3 timeout) share stimulus and are checked against a rule model.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    typedef struct {
        bit       rst_n;
        bit [4:0] rs1, rs2;
        bit       u1, u2;
        bit [4:0] idwr;
        bit       idwe;
        bit [2:0] idsel;
        bit [4:0] xwr;
        bit       xwe;
        bit [2:0] xsel;
        bit       xdwe, xnull;
        bit [4:0] wwr;
        bit       wwe;
        bit       br, rdy;
    } in_t;

    typedef struct {
        bit [3:0] stl;   // pc, ifid, idex, exm
        bit [1:0] fl;    // ifid, idex
        bit [1:0] fa, fb;
    } out_t;

    typedef struct {
        in_t  in;
        out_t ex;
    } vec_t;

    typedef struct {
        int          bubbles;
        int          waited;
        bit          waiting;
        bit          err;
        int unsigned stalls;
    } mdl_t;

    logic clk_i = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_chk  = 0;
    mdl_t ma, mb;
    bit   last_a_pc, last_b_pc, last_b_ifl;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl_if ha ();
    pipe_hazard_ctrl_if hb ();

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(255)) dut_a (
        .clk_i(clk_i), .rst_n_i(rst_n), .hz(ha));
    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(3)) dut_b (
        .clk_i(clk_i), .rst_n_i(rst_n), .hz(hb));

    assign hb.id_rs1_i          = ha.id_rs1_i;
    assign hb.id_rs2_i          = ha.id_rs2_i;
    assign hb.id_use_rs1_i      = ha.id_use_rs1_i;
    assign hb.id_use_rs2_i      = ha.id_use_rs2_i;
    assign hb.idex_wR_i         = ha.idex_wR_i;
    assign hb.idex_rf_we_i      = ha.idex_rf_we_i;
    assign hb.idex_wb_sel_i     = ha.idex_wb_sel_i;
    assign hb.exm_wR_i          = ha.exm_wR_i;
    assign hb.exm_rf_we_i       = ha.exm_rf_we_i;
    assign hb.exm_wb_sel_i      = ha.exm_wb_sel_i;
    assign hb.exm_dram_we_i     = ha.exm_dram_we_i;
    assign hb.exm_null_i        = ha.exm_null_i;
    assign hb.wb_wR_i           = ha.wb_wR_i;
    assign hb.wb_rf_we_i        = ha.wb_rf_we_i;
    assign hb.ex_branch_taken_i = ha.ex_branch_taken_i;
    assign hb.dram_ready_i      = ha.dram_ready_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic bit hit(input bit [4:0] rd, input bit we, input bit [4:0] rs, input bit u);
        return (rd != 5'd0) && (rd == rs) && we && u;
    endfunction

    function automatic bit [1:0] fsel(input in_t x, input bit [4:0] rs, input bit u);
        if (hit(x.xwr, x.xwe, rs, u) && x.xsel != WB_DRAM && !x.xnull) return 2'b01;
        if (hit(x.wwr, x.wwe, rs, u)) return 2'b10;
        return 2'b00;
    endfunction

    // Reference: one cycle of the controller rules, given bubble count and timeout.
    function automatic void model(input mdl_t m, input in_t x, input int nb, input int nt,
                                  output out_t e, output mdl_t n);
        bit acc, lu, hold;
        e = '{default: 0};
        n = m;
        if (!x.rst_n) begin
            e.fl = 2'b11;
            n = '{default: 0};
            return;
        end
        e.fa = fsel(x, x.rs1, x.u1);
        e.fb = fsel(x, x.rs2, x.u2);
        acc  = !x.xnull && (x.xdwe || x.xsel == WB_DRAM);
        lu   = (x.idsel == WB_DRAM) && (hit(x.idwr, x.idwe, x.rs1, x.u1) || hit(x.idwr, x.idwe, x.rs2, x.u2));
        hold = !x.rdy && (m.waiting || acc);
        if (hold) begin
            e.stl = 4'b1111;
            if (m.waiting) begin
                n.waited = m.waited + 1;
                if (n.waited == nt) begin
                    n.err = 1'b1; n.waiting = 1'b0; n.waited = 0; n.bubbles = 0;
                end
            end else begin
                n.waiting = 1'b1;
            end
        end else begin
            n.waiting = 1'b0;
            n.waited  = 0;
            if (x.br) begin
                e.fl = 2'b11; n.bubbles = 0;
            end else if (m.bubbles > 0) begin
                e.stl = 4'b1100; e.fl = 2'b01; n.bubbles = m.bubbles - 1;
            end else if (lu) begin
                e.stl = 4'b1100; e.fl = 2'b01; n.bubbles = nb - 1;
            end
        end
        n.stalls = m.stalls + 32'(e.stl[3]);
    endfunction

    function automatic in_t idle();
        in_t x = '{default: 0};
        x.rst_n = 1'b1; x.xnull = 1'b1; x.rdy = 1'b1;
        return x;
    endfunction

    task automatic apply(input in_t x);
        rst_n                = x.rst_n;
        ha.id_rs1_i          = x.rs1;
        ha.id_rs2_i          = x.rs2;
        ha.id_use_rs1_i      = x.u1;
        ha.id_use_rs2_i      = x.u2;
        ha.idex_wR_i         = x.idwr;
        ha.idex_rf_we_i      = x.idwe;
        ha.idex_wb_sel_i     = x.idsel;
        ha.exm_wR_i          = x.xwr;
        ha.exm_rf_we_i       = x.xwe;
        ha.exm_wb_sel_i      = x.xsel;
        ha.exm_dram_we_i     = x.xdwe;
        ha.exm_null_i        = x.xnull;
        ha.wb_wR_i           = x.wwr;
        ha.wb_rf_we_i        = x.wwe;
        ha.ex_branch_taken_i = x.br;
        ha.dram_ready_i      = x.rdy;
    endtask

    // One clock: drive, compare at the falling edge, advance the model at the rising edge.
    task automatic step(input in_t x, input bit use_tab, input out_t tab);
        out_t ea, eb;
        mdl_t na, nb;
        logic [3:0] sa, sb;
        apply(x);
        @(negedge clk_i);
        model(ma, x, 1, 255, ea, na);
        model(mb, x, 3, 3, eb, nb);
        sa = {ha.pc_stall_o, ha.ifid_stall_o, ha.idex_stall_o, ha.exm_stall_o};
        sb = {hb.pc_stall_o, hb.ifid_stall_o, hb.idex_stall_o, hb.exm_stall_o};
        check("a_stall", 32'(sa), 32'(ea.stl));
        check("a_flush", 32'({ha.ifid_flush_o, ha.idex_flush_o}), 32'(ea.fl));
        check("a_fwd", 32'({ha.fwd_a_o, ha.fwd_b_o}), 32'({ea.fa, ea.fb}));
        check("a_mem_err", 32'(ha.mem_err_o), 32'(ma.err));
        check("a_stall_cnt", ha.stall_cnt_o, ma.stalls);
        check("b_stall", 32'(sb), 32'(eb.stl));
        check("b_flush", 32'({hb.ifid_flush_o, hb.idex_flush_o}), 32'(eb.fl));
        check("b_fwd", 32'({hb.fwd_a_o, hb.fwd_b_o}), 32'({eb.fa, eb.fb}));
        check("b_mem_err", 32'(hb.mem_err_o), 32'(mb.err));
        check("b_stall_cnt", hb.stall_cnt_o, mb.stalls);
        if (use_tab) begin
            check("tab_stall", 32'(sa), 32'(tab.stl));
            check("tab_flush", 32'({ha.ifid_flush_o, ha.idex_flush_o}), 32'(tab.fl));
            check("tab_fwd_a", 32'(ha.fwd_a_o), 32'(tab.fa));
            check("tab_fwd_b", 32'(ha.fwd_b_o), 32'(tab.fb));
        end
        last_a_pc  = ha.pc_stall_o;
        last_b_pc  = hb.pc_stall_o;
        last_b_ifl = hb.ifid_flush_o;
        @(posedge clk_i);
        ma = na;
        mb = nb;
        #1;
    endtask

    task automatic run(input in_t x);
        out_t none = '{default: 0};
        step(x, 1'b0, none);
    endtask

    initial begin
        vec_t tab[$];
        in_t  x, lu, ld;
        out_t o;
        bit [3:0] pa, pb;

        ma = '{default: 0};
        mb = '{default: 0};
        x = idle(); x.rst_n = 1'b0;
        apply(x);
        repeat (2) @(posedge clk_i);
        #1;

        lu = idle(); lu.rs1 = 5'd5; lu.u1 = 1'b1; lu.idwr = 5'd5; lu.idwe = 1'b1; lu.idsel = WB_DRAM;
        ld = idle(); ld.xwr = 5'd3; ld.xwe = 1'b1; ld.xsel = WB_DRAM; ld.xnull = 1'b0; ld.rdy = 1'b0;

        // Directed sequence with expectations for the 1-bubble instance.
        x = idle(); x.rst_n = 1'b0;
        o = '{4'b0000, 2'b11, 2'b00, 2'b00}; tab.push_back('{x, o}); tab.push_back('{x, o});
        o = '{4'b0000, 2'b00, 2'b00, 2'b00}; tab.push_back('{idle(), o});
        o = '{4'b1100, 2'b01, 2'b00, 2'b00}; tab.push_back('{lu, o});
        x = idle(); x.rs1 = 5'd5; x.u1 = 1'b1; x.xwr = 5'd5; x.xwe = 1'b1; x.xsel = WB_DRAM;
        x.xnull = 1'b0; x.wwr = 5'd5; x.wwe = 1'b1;
        o = '{4'b0000, 2'b00, 2'b10, 2'b00}; tab.push_back('{x, o});
        x = idle(); x.rs2 = 5'd7; x.u2 = 1'b1; x.xwr = 5'd7; x.xwe = 1'b1; x.xsel = WB_ALU;
        x.xnull = 1'b0; x.wwr = 5'd7; x.wwe = 1'b1;
        o = '{4'b0000, 2'b00, 2'b00, 2'b01}; tab.push_back('{x, o});
        x.xnull = 1'b1;
        o = '{4'b0000, 2'b00, 2'b00, 2'b10}; tab.push_back('{x, o});
        x.xnull = 1'b0; x.rs2 = 5'd0; x.xwr = 5'd0; x.wwr = 5'd0;
        o = '{4'b0000, 2'b00, 2'b00, 2'b00}; tab.push_back('{x, o});
        x.rs2 = 5'd7; x.xwr = 5'd7; x.wwr = 5'd7; x.u2 = 1'b0;
        tab.push_back('{x, o});
        o = '{4'b1111, 2'b00, 2'b00, 2'b00};
        repeat (4) tab.push_back('{ld, o});
        x = ld; x.rdy = 1'b1;
        o = '{4'b0000, 2'b00, 2'b00, 2'b00}; tab.push_back('{x, o});
        x = lu; x.br = 1'b1;
        o = '{4'b0000, 2'b11, 2'b00, 2'b00}; tab.push_back('{x, o});
        x = ld; x.br = 1'b1;
        o = '{4'b1111, 2'b00, 2'b00, 2'b00}; tab.push_back('{x, o}); tab.push_back('{x, o});
        x.rdy = 1'b1;
        o = '{4'b0000, 2'b11, 2'b00, 2'b00}; tab.push_back('{x, o});
        x = lu; x.xdwe = 1'b1; x.xnull = 1'b0; x.rdy = 1'b0;
        o = '{4'b1111, 2'b00, 2'b00, 2'b00}; tab.push_back('{x, o});
        x.rdy = 1'b1;
        o = '{4'b1100, 2'b01, 2'b00, 2'b00}; tab.push_back('{x, o});
        o = '{4'b1111, 2'b00, 2'b00, 2'b00}; tab.push_back('{ld, o}); tab.push_back('{ld, o});
        x = ld; x.rst_n = 1'b0;
        o = '{4'b0000, 2'b11, 2'b00, 2'b00}; tab.push_back('{x, o}); tab.push_back('{x, o});
        o = '{4'b0000, 2'b00, 2'b00, 2'b00}; tab.push_back('{idle(), o});

        for (int i = 0; i < tab.size(); i++) step(tab[i].in, 1'b1, tab[i].ex);

        // Four-cycle memory wait: 255-timeout instance counts 4 stalls, 3-timeout instance errors.
        x = idle(); x.rst_n = 1'b0;
        run(x);
        run(ld); run(ld); run(ld);
        check("b_err_before_timeout", 32'(hb.mem_err_o), 32'd0);
        run(ld);
        check("b_err_at_timeout", 32'(hb.mem_err_o), 32'd1);
        x = ld; x.rdy = 1'b1;
        run(x);
        check("a_wait_stall_cnt", ha.stall_cnt_o, 32'd4);
        check("a_wait_no_err", 32'(ha.mem_err_o), 32'd0);
        repeat (3) run(idle());
        check("b_err_sticky", 32'(hb.mem_err_o), 32'd1);
        x = idle(); x.rst_n = 1'b0;
        run(x);
        check("b_err_cleared", 32'(hb.mem_err_o), 32'd0);
        check("a_cnt_cleared", ha.stall_cnt_o, 32'd0);

        // Three-bubble load-use on instance B, one bubble on instance A.
        pa = '0; pb = '0;
        run(lu);      pa = {pa[2:0], last_a_pc}; pb = {pb[2:0], last_b_pc};
        repeat (3) begin
            run(idle()); pa = {pa[2:0], last_a_pc}; pb = {pb[2:0], last_b_pc};
        end
        check("a_bubble_pattern", 32'(pa), 32'(4'b1000));
        check("b_bubble_pattern", 32'(pb), 32'(4'b1110));

        // Branch cancels a load stall in progress.
        pb = '0;
        run(lu); pb = {pb[2:0], last_b_pc};
        run(idle()); pb = {pb[2:0], last_b_pc};
        x = idle(); x.br = 1'b1;
        run(x); pb = {pb[2:0], last_b_pc};
        check("b_branch_flush", 32'(last_b_ifl), 32'd1);
        run(idle()); pb = {pb[2:0], last_b_pc};
        check("b_branch_cancel", 32'(pb), 32'(4'b1100));

        // Random traffic on a small register set to provoke frequent matches.
        for (int i = 0; i < 3000; i++) begin
            x.rst_n = ($urandom_range(0, 99) != 0);
            x.rs1   = 5'($urandom_range(0, 3));
            x.rs2   = 5'($urandom_range(0, 3));
            x.u1    = 1'($urandom_range(0, 1));
            x.u2    = 1'($urandom_range(0, 1));
            x.idwr  = 5'($urandom_range(0, 3));
            x.idwe  = 1'($urandom_range(0, 1));
            x.idsel = ($urandom_range(0, 1) != 0) ? WB_DRAM : 3'($urandom_range(0, 4));
            x.xwr   = 5'($urandom_range(0, 3));
            x.xwe   = 1'($urandom_range(0, 1));
            x.xsel  = ($urandom_range(0, 2) == 0) ? WB_DRAM : 3'($urandom_range(0, 4));
            x.xdwe  = ($urandom_range(0, 4) == 0);
            x.xnull = ($urandom_range(0, 3) == 0);
            x.wwr   = 5'($urandom_range(0, 3));
            x.wwe   = 1'($urandom_range(0, 1));
            x.br    = ($urandom_range(0, 7) == 0);
            x.rdy   = ($urandom_range(0, 9) < 7);
            run(x);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the five-stage miniRV pipeline. Drives stall and flush for the PC, IF/ID, ID/EX and EX/DMEM pipeline registers, and generates forwarding selects for the EX operands. Sequences load-use bubbles and multi-cycle data-memory waits, and keeps a stall-cycle counter for performance debug.

Parameters:
LOAD_USE_BUBBLES, 1, bubbles inserted when an ID instruction reads a register loaded by the instruction in ID/EX (range 1-3).
MEM_TIMEOUT, 255, maximum cycles in MEM_WAIT before mem_err_o is raised (8-bit counter).

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous reset, active-low
id_rs1_i / id_rs2_i  in  5  ID-stage source register numbers
id_use_rs1_i / id_use_rs2_i  in  1  ID instruction actually reads rs1 / rs2
idex_wR_i  in  5  destination register in ID/EX
idex_rf_we_i  in  1  register write enable in ID/EX
idex_wb_sel_i  in  3  write-back select in ID/EX
exm_wR_i  in  5  destination register in EX/DMEM
exm_rf_we_i  in  1  register write enable in EX/DMEM
exm_wb_sel_i  in  3  write-back select in EX/DMEM
exm_dram_we_i  in  1  store in EX/DMEM
exm_null_i  in  1  EX/DMEM holds a bubble
wb_wR_i  in  5  destination register in DMEM/WB
wb_rf_we_i  in  1  register write enable in DMEM/WB
ex_branch_taken_i  in  1  EX resolved a taken branch or jump
dram_ready_i  in  1  data memory completes the current access this cycle
pc_stall_o / ifid_stall_o / idex_stall_o / exm_stall_o  out  1  hold the register
ifid_flush_o / idex_flush_o  out  1  load a bubble (null=1) into the register
fwd_a_o / fwd_b_o  out  2  EX operand source: 00 register file, 01 EX/DMEM alu_c, 10 DMEM/WB write-back data
mem_err_o  out  1  sticky memory-timeout flag
stall_cnt_o  out  32  count of cycles with pc_stall_o=1

Behaviour:
- State register: RUN, LOAD_STALL, MEM_WAIT. Updates on posedge clk_i. All stall, flush and forwarding outputs are combinational from state and inputs.
- Reset (rst_n_i=0 sampled at the edge): state=RUN, bubble counter=0, timeout counter=0, mem_err_o=0, stall_cnt_o=0.
- While rst_n_i=0, outputs are forced: all stalls=0, ifid_flush_o=idex_flush_o=1, fwd=00. This holds even when reset is asserted mid-operation.
- Register match rule: the destination is non-zero and equals the source, the writer's rf_we is 1, and the source's use flag is 1. Register x0 never matches.
- Forwarding: an EX/DMEM match with wb_sel!=WB_DRAM and exm_null_i=0 selects 01. Otherwise a DMEM/WB match selects 10. Otherwise 00. EX/DMEM has priority.
- Memory access: exm_null_i=0 and (exm_dram_we_i=1 or exm_wb_sel_i=WB_DRAM).
- Priority per cycle, highest first: memory wait, then branch flush, then load-use.
- RUN to MEM_WAIT: when there is a memory access and dram_ready_i=0.
  - All four stalls=1 and no flush, in the same cycle and for every MEM_WAIT cycle.
- MEM_WAIT exits to RUN in the cycle dram_ready_i=1; stalls drop in that cycle.
  - The timeout counter increments per MEM_WAIT cycle. When it reaches MEM_TIMEOUT, mem_err_o is set and stays set until reset, and the state is forced to RUN.
  - The counter clears on leaving MEM_WAIT.
- Branch: ex_branch_taken_i=1 outside a memory wait gives ifid_flush_o=idex_flush_o=1 and no stalls, for exactly that cycle.
  - If the branch arrives in LOAD_STALL, the stall is cancelled: state goes to RUN and the counter clears.
- Load-use: in RUN, an ID/EX match with idex_wb_sel_i=WB_DRAM gives pc_stall_o=ifid_stall_o=1 and idex_flush_o=1.
  - Load counter=LOAD_USE_BUBBLES-1. If that is non-zero, go to LOAD_STALL.
  - LOAD_STALL repeats the same outputs and decrements the counter. At 0 it returns to RUN.
- A memory wait arriving during LOAD_STALL pre-empts it. The bubble counter is frozen and resumes after MEM_WAIT.
- stall_cnt_o increments when pc_stall_o=1 and wraps at 2^32-1 to 0.

Decomposition:
- Package pipe_pkg holds:
  - WB_ALU=3'd0, WB_DRAM=3'd1, WB_PC4=3'd2, WB_IMM=3'd3, WB_PCIMM=3'd4
  - FWD_RF/FWD_EXM/FWD_WB encodings
  - the state enum
- One sub-module, fwd_unit: purely combinational forwarding select, instantiated once per operand.

Test Plan:
- Load to x5 in ID/EX, ID reads rs1=x5, LOAD_USE_BUBBLES=1 -> one cycle of pc/ifid stall plus idex_flush, then RUN; next cycle fwd_a_o=10.
- ALU write to x7 in EX/DMEM and DMEM/WB both writing x7, rs2=x7 -> fwd_b_o=01; with rs2=x0 and wR=x0 -> 00.
- Load in EX/DMEM, dram_ready_i low for 4 cycles -> all stalls=1 for 4 cycles, released in the ready cycle, stall_cnt_o+=4, mem_err_o=0.
- MEM_TIMEOUT=3, ready never asserted -> mem_err_o=1 after the 3rd wait cycle, state RUN, flag sticky until rst_n_i=0.
- Branch taken in the same cycle as a load-use match -> flush only, no stall; during a pending memory wait -> stall only, flush taken the cycle ready rises.
- Assert rst_n_i in MEM_WAIT -> next edge: state RUN, counters 0, flushes=1 while reset is held.
